comparator_bist: RTL and testbench



---
 rtl/comparator_bist.sv | 136 +++++++++++++
 tb/tb_comparator_bist.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_bist.sv
// Built-in self-test engine for WIDTH-bit magnitude comparators: sweeps all operand pairs and checks the four flags.
// Optional macro COMPARATOR_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module comparator_bist #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 0,
  parameter int ERR_W  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  output logic [WIDTH-1:0]     o_a,
  output logic [WIDTH-1:0]     o_b,
  input  logic                 i_equal,
  input  logic                 i_not_equal,
  input  logic                 i_great_a,
  input  logic                 i_great_b,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [ERR_W-1:0]     o_err_cnt,
  output logic [2*WIDTH-1:0]   o_fail_idx
);

  localparam int IW   = 2 * WIDTH;
  localparam int HC_W = 4;

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [HC_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic [ERR_W-1:0]  err_cnt, err_cnt_nxt, err_upd;
  logic [IW-1:0]     fail_idx, fail_idx_nxt;
  logic              busy, busy_nxt;
  logic              done, done_nxt;
  logic              pass, pass_nxt;
  logic [WIDTH-1:0]  cur_a, cur_b;
  logic [3:0]        flags, golden;
  logic              sample, mismatch, stop;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
  endfunction

  assign cur_a    = idx[WIDTH-1:0];
  assign cur_b    = idx[IW-1:WIDTH];
  assign flags    = {i_equal, i_not_equal, i_great_a, i_great_b};
  assign golden   = {cur_a == cur_b, cur_a != cur_b, cur_a > cur_b, cur_b > cur_a};
  assign sample   = (hold_cnt == HC_W'(SETTLE));
  assign mismatch = (flags != golden);
  assign err_upd  = mismatch ? sat_inc(err_cnt) : err_cnt;

`ifdef COMPARATOR_BIST_STOP_ON_FAIL_EN
  assign stop = mismatch;
`else
  assign stop = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    hold_cnt_nxt = hold_cnt;
    err_cnt_nxt  = err_cnt;
    fail_idx_nxt = fail_idx;
    busy_nxt     = busy;
    done_nxt     = done;
    pass_nxt     = pass;
    case (state)
      IDLE, DONE: begin
        if (i_start) begin
          state_nxt    = HOLD;
          idx_nxt      = '0;
          hold_cnt_nxt = '0;
          err_cnt_nxt  = '0;
          fail_idx_nxt = '0;
          busy_nxt     = 1'b1;
          done_nxt     = 1'b0;
          pass_nxt     = 1'b0;
        end
      end
      HOLD: begin
        if (!sample) begin
          hold_cnt_nxt = hold_cnt + HC_W'(1);
        end else begin
          hold_cnt_nxt = '0;
          err_cnt_nxt  = err_upd;
          // The counter never wraps back to zero, so zero means no mismatch yet this sweep.
          if (mismatch && (err_cnt == '0)) fail_idx_nxt = idx;
          if (stop || (idx == {IW{1'b1}})) begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = (err_upd == '0);
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idx      <= '0;
      hold_cnt <= '0;
      err_cnt  <= '0;
      fail_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      idx      <= idx_nxt;
      hold_cnt <= hold_cnt_nxt;
      err_cnt  <= err_cnt_nxt;
      fail_idx <= fail_idx_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      pass     <= pass_nxt;
    end
  end

  assign o_a        = cur_a;
  assign o_b        = cur_b;
  assign o_busy     = busy;
  assign o_done     = done;
  assign o_pass     = pass;
  assign o_err_cnt  = err_cnt;
  assign o_fail_idx = fail_idx;

endmodule

// File: tb/tb_comparator_bist.sv
// Bench for comparator_bist: two instances (W1/S0/E8 and W2/S1/E2) each driving a faultable comparator model.
module tb_comparator_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start0, start1;
  logic [0:0] a0, b0;
  logic [1:0] a1, b1;
  logic eq0, ne0, ga0, gb0, eq1, ne1, ga1, gb1;
  logic busy0, done0, pass0, busy1, done1, pass1;
  logic [7:0] err0;
  logic [1:0] err1;
  logic [1:0] fidx0;
  logic [3:0] fidx1;

  // fault modes: 0 golden, 1 great_a stuck 0, 2 equal inverted, 3 not_equal flipped on masked vectors
  int fmode [2];
  bit mask [2][16];

  comparator_bist #(.WIDTH(1), .SETTLE(0), .ERR_W(8)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .o_a(a0), .o_b(b0),
    .i_equal(eq0), .i_not_equal(ne0), .i_great_a(ga0), .i_great_b(gb0),
    .o_busy(busy0), .o_done(done0), .o_pass(pass0), .o_err_cnt(err0), .o_fail_idx(fidx0));

  comparator_bist #(.WIDTH(2), .SETTLE(1), .ERR_W(2)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .o_a(a1), .o_b(b1),
    .i_equal(eq1), .i_not_equal(ne1), .i_great_a(ga1), .i_great_b(gb1),
    .o_busy(busy1), .o_done(done1), .o_pass(pass1), .o_err_cnt(err1), .o_fail_idx(fidx1));

  always_comb begin
    eq0 = (a0 == b0) ^ (fmode[0] == 2);
    ne0 = (a0 != b0) ^ (fmode[0] == 3 && mask[0][{b0, a0}]);
    ga0 = (a0 > b0) && (fmode[0] != 1);
    gb0 = (b0 > a0);
    eq1 = (a1 == b1) ^ (fmode[1] == 2);
    ne1 = (a1 != b1) ^ (fmode[1] == 3 && mask[1][{b1, a1}]);
    ga1 = (a1 > b1) && (fmode[1] != 1);
    gb1 = (b1 > a1);
  end

  typedef struct {
    int d;
    int mode;
    bit pulse_hold;
    int exp_err;
    int exp_fidx;
    int exp_done;
    int exp_last;
    bit exp_pass;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int get_idx(input int d);
    return (d == 0) ? int'({b0, a0}) : int'({b1, a1});
  endfunction
  function automatic int get_err(input int d);
    return (d == 0) ? int'(err0) : int'(err1);
  endfunction
  function automatic int get_fidx(input int d);
    return (d == 0) ? int'(fidx0) : int'(fidx1);
  endfunction
  function automatic int get_busy(input int d);
    return (d == 0) ? int'(busy0) : int'(busy1);
  endfunction
  function automatic int get_done(input int d);
    return (d == 0) ? int'(done0) : int'(done1);
  endfunction
  function automatic int get_pass(input int d);
    return (d == 0) ? int'(pass0) : int'(pass1);
  endfunction

  task automatic set_start(input int d, input logic v);
    if (d == 0) start0 = v;
    else        start1 = v;
  endtask

  // Reference: list the vectors the faulty comparator gets wrong, then derive the sweep outcome.
  function automatic vec_t model(input int d, input int mode, input bit ph);
    vec_t r;
    int w, s, ew, v;
    int bad[$];
    w  = (d == 0) ? 1 : 2;
    s  = (d == 0) ? 0 : 1;
    ew = (d == 0) ? 8 : 2;
    v  = 1 << (2 * w);
    for (int k = 0; k < v; k++) begin
      int a, b;
      bit isbad;
      a = k % (1 << w);
      b = k / (1 << w);
      case (mode)
        1:       isbad = (a > b);
        2:       isbad = 1'b1;
        3:       isbad = mask[d][k];
        default: isbad = 1'b0;
      endcase
      if (isbad) bad.push_back(k);
    end
    r.d = d; r.mode = mode; r.pulse_hold = ph;
    r.exp_fidx = (bad.size() > 0) ? bad[0] : 0;
`ifdef COMPARATOR_BIST_STOP_ON_FAIL_EN
    if (bad.size() > 0) begin
      r.exp_err  = 1;
      r.exp_done = (bad[0] + 1) * (s + 1);
      r.exp_last = bad[0];
      r.exp_pass = 1'b0;
      return r;
    end
`endif
    r.exp_err  = (bad.size() > (1 << ew) - 1) ? (1 << ew) - 1 : bad.size();
    r.exp_done = v * (s + 1);
    r.exp_last = v - 1;
    r.exp_pass = (bad.size() == 0);
    return r;
  endfunction

  task automatic run(input vec_t t, input int n);
    int s, limit, bad_seq, done_at, err_at;
    s       = (t.d == 0) ? 0 : 1;
    limit   = (1 << (2 * ((t.d == 0) ? 1 : 2))) * (s + 1) + 10;
    bad_seq = 0;
    done_at = -1;
    fmode[t.d] = t.mode;
    @(negedge clk);
    set_start(t.d, 1'b1);
    @(negedge clk);
    set_start(t.d, 1'b0);
    for (int c = 0; c <= limit; c++) begin
      if (c > 0) @(negedge clk);
      if (t.pulse_hold && t.exp_done > 4 && c == 2) set_start(t.d, 1'b1);
      if (c == 3) set_start(t.d, 1'b0);
      if (get_done(t.d) == 1) begin
        done_at = c;
        break;
      end
      if (get_busy(t.d) != 1 || get_idx(t.d) != c / (s + 1)) bad_seq++;
    end
    check($sformatf("case%0d_done_cycle", n), done_at, t.exp_done);
    check($sformatf("case%0d_vector_seq_errors", n), bad_seq, 0);
    check($sformatf("case%0d_busy_at_done", n), get_busy(t.d), 0);
    check($sformatf("case%0d_err_cnt", n), get_err(t.d), t.exp_err);
    check($sformatf("case%0d_pass", n), get_pass(t.d), int'(t.exp_pass));
    check($sformatf("case%0d_last_vector", n), get_idx(t.d), t.exp_last);
    if (t.exp_err != 0) check($sformatf("case%0d_fail_idx", n), get_fidx(t.d), t.exp_fidx);
    err_at = get_err(t.d);
    repeat (3) @(negedge clk);
    check($sformatf("case%0d_done_held", n), get_done(t.d), 1);
    check($sformatf("case%0d_err_held", n), get_err(t.d), err_at);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dut0_outputs"}, int'({a0, b0, busy0, done0, pass0, err0, fidx0}), 0);
    check({tag, "_dut1_outputs"}, int'({a1, b1, busy1, done1, pass1, err1, fidx1}), 0);
  endtask

  vec_t tbl [7];

  initial begin
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
    fmode[0] = 0; fmode[1] = 0;
    for (int k = 0; k < 16; k++) begin
      mask[0][k] = ($urandom_range(0, 2) == 0);
      mask[1][k] = ($urandom_range(0, 3) == 0);
    end
    tbl[0] = '{0, 0, 1'b0, 0, 0, 4, 3, 1'b1};
    tbl[2] = '{1, 0, 1'b0, 0, 0, 32, 15, 1'b1};
`ifdef COMPARATOR_BIST_STOP_ON_FAIL_EN
    tbl[1] = '{0, 1, 1'b0, 1, 1, 2, 1, 1'b0};
    tbl[3] = '{1, 2, 1'b1, 1, 0, 2, 0, 1'b0};
    tbl[4] = '{1, 1, 1'b0, 1, 1, 4, 1, 1'b0};
`else
    tbl[1] = '{0, 1, 1'b0, 1, 1, 4, 3, 1'b0};
    tbl[3] = '{1, 2, 1'b1, 3, 0, 32, 15, 1'b0};
    tbl[4] = '{1, 1, 1'b0, 3, 1, 32, 15, 1'b0};
`endif
    tbl[5] = model(0, 3, 1'b0);
    tbl[6] = model(1, 3, 1'b1);

    #2 rst = 1'b1;
    #2 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy0_no_start", int'(busy0), 0);
    check("idle_busy1_no_start", int'(busy1), 0);

    for (int i = 0; i < 7; i++) run(tbl[i], i);

    // Mid-sweep asynchronous reset, asserted between edges after E0+2.
    fmode[0] = 1;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (2) @(negedge clk);
    check("midsweep_busy_before_reset", int'(busy0), 1);
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_idle_busy", int'(busy0), 0);
    check("post_reset_idle_done", int'(done0), 0);

    run(tbl[0], 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
